// File: rtl/ex_mem_skid_reg_if.sv
// Execute-to-memory handshake bundle: upstream valid/ready with the ALU
// result and control bits, downstream valid/ready with the registered copy.
// StallCount exists only when EXMEM_STALL_CNT_EN is defined.
interface ex_mem_skid_reg_if #(
  parameter int n = 64
);
  logic         InValid;
  logic         InReady;
  logic [n-1:0] InBusW;
  logic         InZero;
  logic [4:0]   InRd;
  logic         InRegWrite;
  logic         InMemRead;
  logic         InMemWrite;
  logic [n-1:0] InStoreData;
  logic         OutValid;
  logic         OutReady;
  logic [n-1:0] OutBusW;
  logic         OutZero;
  logic [4:0]   OutRd;
  logic         OutRegWrite;
  logic         OutMemRead;
  logic         OutMemWrite;
  logic [n-1:0] OutStoreData;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0]  StallCount;
`endif

  // Environment side: drives the execute inputs and the memory-stage ready.
  modport master (
    output InValid, InBusW, InZero, InRd, InRegWrite, InMemRead, InMemWrite,
           InStoreData, OutReady,
    input  InReady, OutValid, OutBusW, OutZero, OutRd, OutRegWrite,
           OutMemRead, OutMemWrite, OutStoreData
`ifdef EXMEM_STALL_CNT_EN
    , input StallCount
`endif
  );

  // Buffer side.
  modport slave (
    input  InValid, InBusW, InZero, InRd, InRegWrite, InMemRead, InMemWrite,
           InStoreData, OutReady,
    output InReady, OutValid, OutBusW, OutZero, OutRd, OutRegWrite,
           OutMemRead, OutMemWrite, OutStoreData
`ifdef EXMEM_STALL_CNT_EN
    , output StallCount
`endif
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary: two-entry skid buffer (main + skid) between the
// ALU and the data-memory stage. InReady is a pure flop output, so no
// combinational ready path reaches back into execute. Flush squashes both
// entries synchronously.
// Optional: define EXMEM_STALL_CNT_EN to add a saturating StallCount output.
module ex_mem_skid_reg #(
  parameter int n = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  ex_mem_skid_reg_if.slave bus
);

  typedef struct packed {
    logic [n-1:0] bus_w;
    logic         zero;
    logic [4:0]   rd;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic [n-1:0] store_data;
  } entry_t;

  entry_t in_entry;
  entry_t main_entry;
  entry_t skid_entry;
  logic   main_vld;
  logic   skid_vld;
  logic   accept;
  logic   drain;

  assign in_entry = {bus.InBusW, bus.InZero, bus.InRd, bus.InRegWrite,
                     bus.InMemRead, bus.InMemWrite, bus.InStoreData};

  assign accept = bus.InValid && !skid_vld;
  assign drain  = main_vld && bus.OutReady;

  // Main/skid entry update: flush first, then refill main, else spill to skid.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      main_vld   <= 1'b0;
      skid_vld   <= 1'b0;
      main_entry <= '0;
      skid_entry <= '0;
    end else if (Flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!main_vld || drain) begin
      if (skid_vld) begin
        // InReady was low, so no accept can collide with this move.
        main_entry <= skid_entry;
        main_vld   <= 1'b1;
        skid_vld   <= 1'b0;
      end else if (accept) begin
        main_entry <= in_entry;
        main_vld   <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_entry <= in_entry;
      skid_vld   <= 1'b1;
    end
  end

  assign bus.InReady      = !skid_vld;
  assign bus.OutValid     = main_vld;
  assign bus.OutBusW      = main_entry.bus_w;
  assign bus.OutZero      = main_entry.zero;
  assign bus.OutRd        = main_entry.rd;
  assign bus.OutRegWrite  = main_entry.reg_write;
  assign bus.OutMemRead   = main_entry.mem_read;
  assign bus.OutMemWrite  = main_entry.mem_write;
  assign bus.OutStoreData = main_entry.store_data;

`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Count memory-stage back-pressure cycles; saturate, ignore Flush.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (main_vld && !bus.OutReady && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed steps then random traffic, all checked
// against a two-deep FIFO reference model held in a queue.
module tb_ex_mem_skid_reg;

  typedef struct packed {
    logic [63:0] busw;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [63:0] sd;
  } ent_t;

  logic CLK = 1'b0;
  logic Reset;
  logic Flush;
  int   total = 0;
  int   bad = 0;
  ent_t q[$];
  logic [31:0] cnt_model;

  ex_mem_skid_reg_if #(.n(64)) bus ();

  ex_mem_skid_reg #(.n(64)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .Flush (Flush),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] bw, input logic z,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [63:0] sd);
    bus.InValid     = v;
    bus.InBusW      = bw;
    bus.InZero      = z;
    bus.InRd        = rd;
    bus.InRegWrite  = rw;
    bus.InMemRead   = mr;
    bus.InMemWrite  = mw;
    bus.InStoreData = sd;
  endtask

  // Reference: a FIFO of capacity two; ready while not full, head is output.
  task automatic model_edge();
    bit   acc;
    bit   drn;
    ent_t e;
    acc = bus.InValid && (q.size() < 2);
    drn = (q.size() > 0) && bus.OutReady;
    if ((q.size() > 0) && !bus.OutReady && (cnt_model != 32'hFFFF_FFFF))
      cnt_model = cnt_model + 32'd1;
    if (Flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        e = '{bus.InBusW, bus.InZero, bus.InRd, bus.InRegWrite,
              bus.InMemRead, bus.InMemWrite, bus.InStoreData};
        q.push_back(e);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_inready"}, 64'(bus.InReady), 64'(q.size() < 2));
    chk({tag, "_outvalid"}, 64'(bus.OutValid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, "_busw"}, bus.OutBusW, q[0].busw);
      chk({tag, "_zero"}, 64'(bus.OutZero), 64'(q[0].zero));
      chk({tag, "_rd"}, 64'(bus.OutRd), 64'(q[0].rd));
      chk({tag, "_regwrite"}, 64'(bus.OutRegWrite), 64'(q[0].rw));
      chk({tag, "_memread"}, 64'(bus.OutMemRead), 64'(q[0].mr));
      chk({tag, "_memwrite"}, 64'(bus.OutMemWrite), 64'(q[0].mw));
      chk({tag, "_storedata"}, bus.OutStoreData, q[0].sd);
    end
`ifdef EXMEM_STALL_CNT_EN
    chk({tag, "_stallcnt"}, 64'(bus.StallCount), 64'(cnt_model));
`endif
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_outvalid"}, 64'(bus.OutValid), 64'd0);
    chk({tag, "_inready"}, 64'(bus.InReady), 64'd1);
    chk({tag, "_busw"}, bus.OutBusW, 64'd0);
    chk({tag, "_zero"}, 64'(bus.OutZero), 64'd0);
    chk({tag, "_rd"}, 64'(bus.OutRd), 64'd0);
    chk({tag, "_ctl"}, 64'({bus.OutRegWrite, bus.OutMemRead, bus.OutMemWrite}), 64'd0);
    chk({tag, "_storedata"}, bus.OutStoreData, 64'd0);
`ifdef EXMEM_STALL_CNT_EN
    chk({tag, "_stallcnt"}, 64'(bus.StallCount), 64'd0);
`endif
  endtask

  // Asynchronous reset pulse starting mid-cycle, released after one edge.
  task automatic pulse_reset(input string tag);
    Reset = 1'b1;
    #2;
    q.delete();
    cnt_model = 32'd0;
    check_reset_state(tag);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Flush = 1'b0;
    bus.OutReady = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    cnt_model = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset");
    Reset = 1'b0;

    // First word, 1-cycle latency.
    bus.OutReady = 1'b1;
    drive(1'b1, 64'h5, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 64'd0);
    cycle("first");
    chk("first_busw_const", bus.OutBusW, 64'h5);
    chk("first_valid_const", 64'(bus.OutValid), 64'd1);
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle("idle");

    // Back-to-back stream at full rate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h10 + 64'(i), 1'b0, 5'(i), 1'b1, 1'b0, 1'b0, 64'(i));
      cycle("stream");
      chk("stream_busw_const", bus.OutBusW, 64'h10 + 64'(i));
      chk("stream_inready_const", 64'(bus.InReady), 64'd1);
    end
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle("stream_end");

    // Back-pressure: 0xA held in main, 0xB in skid, ready drops.
    bus.OutReady = 1'b0;
    drive(1'b1, 64'hA, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 64'd0);
    cycle("bp_a");
    drive(1'b1, 64'hB, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 64'd0);
    cycle("bp_b");
    chk("bp_hold_busw_const", bus.OutBusW, 64'hA);
    chk("bp_full_inready_const", 64'(bus.InReady), 64'd0);
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle("bp_hold");
    chk("bp_hold2_busw_const", bus.OutBusW, 64'hA);
    bus.OutReady = 1'b1;
    cycle("bp_drain_a");
    chk("bp_drain_b_const", bus.OutBusW, 64'hB);
    chk("bp_drain_inready_const", 64'(bus.InReady), 64'd1);
    cycle("bp_drain_b");
    chk("bp_empty_const", 64'(bus.OutValid), 64'd0);

    // Full buffer flushed while 0xC is offered: 0xC never appears.
    bus.OutReady = 1'b0;
    drive(1'b1, 64'hA, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle("fl_a");
    drive(1'b1, 64'hB, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle("fl_b");
    drive(1'b1, 64'hC, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 64'd0);
    Flush = 1'b1;
    cycle("flush");
    chk("flush_valid_const", 64'(bus.OutValid), 64'd0);
    chk("flush_inready_const", 64'(bus.InReady), 64'd1);
    Flush = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    bus.OutReady = 1'b1;
    cycle("flush_after");
    chk("flush_noc_const", 64'(bus.OutValid), 64'd0);

    // Field passthrough including XZR destination.
    drive(1'b1, 64'd0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    cycle("fields");
    chk("fields_rd_const", 64'(bus.OutRd), 64'd31);
    chk("fields_sd_const", bus.OutStoreData, 64'hDEAD_BEEF_0000_0001);
    chk("fields_mw_const", 64'(bus.OutMemWrite), 64'd1);
    chk("fields_zero_const", 64'(bus.OutZero), 64'd1);
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle("fields_end");

`ifdef EXMEM_STALL_CNT_EN
    // Stall counter: 7 stalled edges, flush leaves it, reset clears it.
    pulse_reset("cnt_reset");
    bus.OutReady = 1'b0;
    drive(1'b1, 64'h77, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 64'd0);
    cycle("cnt_load");
    drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (7) cycle("cnt_stall");
    chk("cnt_seven_const", 64'(bus.StallCount), 64'd7);
    bus.OutReady = 1'b1;
    Flush = 1'b1;
    cycle("cnt_flush");
    Flush = 1'b0;
    chk("cnt_flush_const", 64'(bus.StallCount), 64'd7);
    pulse_reset("cnt_cleared");
`endif

    // Random traffic with occasional flush and a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      bus.OutReady = ($urandom_range(0, 9) < 6);
      Flush = ($urandom_range(0, 24) == 0);
      if (i == 300) begin
        Flush = 1'b0;
        pulse_reset("rnd_reset");
      end else begin
        cycle("rnd");
      end
    end
    Flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
